// File: rtl/serial_mod_detector.sv
// serial_mod_detector: bit-serial running remainder modulo DIVISOR.
// A number is streamed one bit per qualified cycle, MSB-first or LSB-first
// (chosen on its first bit). dout flags "value so far is a multiple of
// DIVISOR" for every bit of the number currently in progress.
//
// Input handshake: din_valid qualifies din/start/lsb_first on each posedge.
// There is no ready; every qualified bit is consumed on the edge where it is
// presented, and nothing changes on cycles with din_valid=0.
module serial_mod_detector #(
    parameter int DIVISOR = 5,
    parameter int CNT_W   = 8,
    localparam int RW     = (DIVISOR > 2) ? $clog2(DIVISOR) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din,
    input  logic             start,
    input  logic             lsb_first,
    output logic             dout,
    output logic [RW-1:0]    rem,
    output logic [CNT_W-1:0] nbits,
    output logic             active
);

    // Divisor and constants at the widened (RW+1) arithmetic width.
    localparam logic [RW:0]       DIV_W    = (RW + 1)'(DIVISOR);
    localparam logic [RW-1:0]     POW_INIT = RW'(2 % DIVISOR);
    localparam logic [RW-1:0]     POW_RST  = RW'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [RW-1:0]    rem_q,    rem_d;
    logic [RW-1:0]    pow_q,    pow_d;
    logic             mode_q,   mode_d;
    logic [CNT_W-1:0] nbits_q,  nbits_d;
    logic             active_q, active_d;
    logic             dout_q,   dout_d;

    logic [RW:0] msb_sum;
    logic [RW:0] lsb_sum;
    logic [RW:0] pow_dbl;
    logic        first_bit;

    // Any operand here is below 2*DIVISOR, so one conditional subtract
    // brings it back into range.
    function automatic logic [RW-1:0] reduce(input logic [RW:0] x);
        logic [RW:0] t;
        t = (x >= DIV_W) ? (x - DIV_W) : x;
        return t[RW-1:0];
    endfunction

    // Next-state computation for remainder, weight, mode, count and flags.
    always_comb begin
        rem_d     = rem_q;
        pow_d     = pow_q;
        mode_d    = mode_q;
        nbits_d   = nbits_q;
        active_d  = active_q;
        // 2*rem + din is just the remainder with din appended.
        msb_sum   = {rem_q, din};
        lsb_sum   = {1'b0, rem_q} + (din ? {1'b0, pow_q} : '0);
        pow_dbl   = {pow_q, 1'b0};
        first_bit = start || !active_q;

        if (din_valid) begin
            if (first_bit) begin
                mode_d   = lsb_first;
                rem_d    = RW'(din);
                pow_d    = POW_INIT;
                nbits_d  = CNT_W'(1);
                active_d = 1'b1;
            end else begin
                if (mode_q) begin
                    rem_d = reduce(lsb_sum);
                    pow_d = reduce(pow_dbl);
                end else begin
                    rem_d = reduce(msb_sum);
                end
                nbits_d = (nbits_q == CNT_MAX) ? nbits_q : (nbits_q + CNT_W'(1));
            end
        end

        dout_d = active_d && (rem_d == '0);
    end

    // State registers with synchronous reset taking priority over any bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q    <= '0;
            pow_q    <= POW_RST;
            mode_q   <= 1'b0;
            nbits_q  <= '0;
            active_q <= 1'b0;
            dout_q   <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            pow_q    <= pow_d;
            mode_q   <= mode_d;
            nbits_q  <= nbits_d;
            active_q <= active_d;
            dout_q   <= dout_d;
        end
    end

    assign dout   = dout_q;
    assign rem    = rem_q;
    assign nbits  = nbits_q;
    assign active = active_q;

endmodule

// File: tb/tb_serial_mod_detector.sv
// Bench for serial_mod_detector: three instances (DIVISOR 5, 3, 7) share one
// input stream. A reference model using integer % arithmetic pushes the
// expected packed outputs per instance; each step pops and compares them.
// Directed steps also check literal values from hand-worked examples.
module tb_serial_mod_detector;

    localparam int W = 18;  // {active, dout, nbits[7:0], rem zero-extended to 8}

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic reset, din_valid, din, start, lsb_first;

    logic       dout5, dout3, dout7;
    logic [2:0] rem5;
    logic [1:0] rem3;
    logic [2:0] rem7;
    logic [7:0] nbits5, nbits3, nbits7;
    logic       active5, active3, active7;

    always #5 clk = ~clk;

    serial_mod_detector #(.DIVISOR(5), .CNT_W(8)) dut5 (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
        .start(start), .lsb_first(lsb_first),
        .dout(dout5), .rem(rem5), .nbits(nbits5), .active(active5));

    serial_mod_detector #(.DIVISOR(3), .CNT_W(8)) dut3 (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
        .start(start), .lsb_first(lsb_first),
        .dout(dout3), .rem(rem3), .nbits(nbits3), .active(active3));

    serial_mod_detector #(.DIVISOR(7), .CNT_W(8)) dut7 (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
        .start(start), .lsb_first(lsb_first),
        .dout(dout7), .rem(rem7), .nbits(nbits7), .active(active7));

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp5_q[$];
    logic [W-1:0] exp3_q[$];
    logic [W-1:0] exp7_q[$];

    int div_n[3] = '{5, 3, 7};
    int m_rem[3];
    int m_pow[3];
    int m_nbits;
    bit m_mode;
    bit m_active;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_exp(input int idx);
        logic [7:0] n8;
        logic [7:0] r8;
        logic       d;
        n8 = m_nbits[7:0];
        r8 = m_rem[idx][7:0];
        d  = m_active && (m_rem[idx] == 0);
        return {m_active, d, n8, r8};
    endfunction

    task automatic model_step(input bit v, input bit d, input bit s, input bit l, input bit r);
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                m_rem[i] = 0;
                m_pow[i] = 1;
            end
            m_mode = 0; m_nbits = 0; m_active = 0;
        end else if (v) begin
            if (s || !m_active) begin
                m_mode = l;
                for (int i = 0; i < 3; i++) begin
                    m_rem[i] = d;
                    m_pow[i] = 2 % div_n[i];
                end
                m_nbits  = 1;
                m_active = 1;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (!m_mode) begin
                        m_rem[i] = (2 * m_rem[i] + d) % div_n[i];
                    end else begin
                        m_rem[i] = (m_rem[i] + (d ? m_pow[i] : 0)) % div_n[i];
                        m_pow[i] = (2 * m_pow[i]) % div_n[i];
                    end
                end
                m_nbits = (m_nbits == 255) ? 255 : m_nbits + 1;
            end
        end
        exp5_q.push_back(pack_exp(0));
        exp3_q.push_back(pack_exp(1));
        exp7_q.push_back(pack_exp(2));
    endtask

    task automatic sb_compare(input string tag);
        logic [W-1:0] e;
        e = exp5_q.pop_front();
        check({tag, "/d5"}, 32'({active5, dout5, nbits5, 8'(rem5)}), 32'(e));
        e = exp3_q.pop_front();
        check({tag, "/d3"}, 32'({active3, dout3, nbits3, 8'(rem3)}), 32'(e));
        e = exp7_q.pop_front();
        check({tag, "/d7"}, 32'({active7, dout7, nbits7, 8'(rem7)}), 32'(e));
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit v, input bit d, input bit s, input bit l, input bit r,
                        input string tag);
        din_valid = v; din = d; start = s; lsb_first = l; reset = r;
        model_step(v, d, s, l, r);
        @(posedge clk);
        #1;
        sb_compare(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, $urandom_range(0, 1), $urandom_range(0, 1),
                                         $urandom_range(0, 1), 0, tag);
    endtask

    task automatic rand_stream(input int len, input bit lsb, input bit toggle_order,
                               input bit gaps, input string tag);
        bit l;
        for (int i = 0; i < len; i++) begin
            l = (i > 0 && toggle_order) ? bit'($urandom_range(0, 1)) : lsb;
            step(1, $urandom_range(0, 1), (i == 0), l, 0, tag);
            if (gaps && $urandom_range(0, 7) == 0) idle(1, tag);
        end
    endtask

    // ---------------- directed sequence ----------------
    int exp_rem[4];
    int exp_dout[4];

    initial begin
        din_valid = 0; din = 0; start = 0; lsb_first = 0; reset = 1;

        // Reset state, then an empty number (no qualified bits).
        step(0, 0, 0, 0, 1, "rst0");
        step(0, 0, 0, 0, 1, "rst1");
        check("rst_rem", 32'(rem5), 0);
        check("rst_dout", 32'(dout5), 0);
        check("rst_active", 32'(active5), 0);
        check("rst_nbits", 32'(nbits5), 0);
        idle(2, "empty");
        check("empty_dout", 32'(dout5), 0);

        // MSB-first 1,0,1,0 -> rem 1,2,0,0
        exp_rem  = '{1, 2, 0, 0};
        exp_dout = '{0, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            step(1, (i % 2 == 0), (i == 0), 0, 0, "msb10");
            check("msb10_rem", 32'(rem5), 32'(exp_rem[i]));
            check("msb10_dout", 32'(dout5), 32'(exp_dout[i]));
            check("msb10_nbits", 32'(nbits5), 32'(i + 1));
        end

        // LSB-first 0,1,0,1 -> rem 0,2,2,0
        exp_rem  = '{0, 2, 2, 0};
        exp_dout = '{1, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            step(1, (i % 2 == 1), (i == 0), 1, 0, "lsb10");
            check("lsb10_rem", 32'(rem5), 32'(exp_rem[i]));
            check("lsb10_dout", 32'(dout5), 32'(exp_dout[i]));
        end

        // Gaps: MSB 1,1,0 with three idle cycles between bits.
        step(1, 1, 1, 0, 0, "gap");
        idle(3, "gap_idle");
        check("gap_hold_rem", 32'(rem5), 1);
        step(1, 1, 0, 1, 0, "gap");
        idle(3, "gap_idle");
        check("gap_hold_nbits", 32'(nbits5), 2);
        step(1, 0, 0, 1, 0, "gap");
        idle(3, "gap_idle");
        check("gap_rem", 32'(rem5), 1);
        check("gap_dout", 32'(dout5), 0);
        check("gap_nbits", 32'(nbits5), 3);

        // Restart mid-number, then reset beside a valid bit.
        step(1, 1, 1, 0, 0, "rs");
        step(1, 1, 0, 0, 0, "rs");
        check("rs_rem3", 32'(rem5), 3);
        step(1, 0, 1, 0, 0, "rs_start");
        check("rs_rem", 32'(rem5), 0);
        check("rs_dout", 32'(dout5), 1);
        check("rs_nbits", 32'(nbits5), 1);
        step(1, 1, 0, 0, 1, "rs_reset");
        check("rs_reset_rem", 32'(rem5), 0);
        check("rs_reset_dout", 32'(dout5), 0);
        check("rs_reset_active", 32'(active5), 0);
        step(1, 1, 0, 1, 0, "rs_after");
        check("rs_after_nbits", 32'(nbits5), 1);
        check("rs_after_rem", 32'(rem5), 1);

        // DIVISOR=7 LSB-first 1,1,1 -> rem 1,3,0; again with order toggled.
        exp_rem  = '{1, 3, 0, 0};
        exp_dout = '{0, 0, 1, 0};
        for (int i = 0; i < 3; i++) begin
            step(1, 1, (i == 0), 1, 0, "d7lsb");
            check("d7lsb_rem", 32'(rem7), 32'(exp_rem[i]));
            check("d7lsb_dout", 32'(dout7), 32'(exp_dout[i]));
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 1, (i == 0), (i == 0), 0, "d7tog");
            check("d7tog_rem", 32'(rem7), 32'(exp_rem[i]));
            check("d7tog_dout", 32'(dout7), 32'(exp_dout[i]));
        end

        // Random streams: MSB 64-bit numbers, LSB with order toggling, gaps.
        for (int k = 0; k < 4; k++) rand_stream(64, 0, 0, 1, "rnd_msb");
        for (int k = 0; k < 3; k++) rand_stream(48, 1, 1, 1, "rnd_lsb");

        // Long MSB number: counter saturates, remainder keeps tracking.
        rand_stream(300, 0, 0, 0, "long");
        check("sat_nbits", 32'(nbits3), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_mod_detector.md
# serial_mod_detector

Bit-serial divisibility detector. It tracks the running remainder of a binary number streamed one bit per qualified cycle, modulo a compile-time divisor. It supports MSB-first or LSB-first ordering, selected per number, and explicit framing of new numbers. It is the parametrised successor to the fixed divide-by-5, MSB-first detector and sits on serial data paths that need a per-bit "value so far is a multiple of N" flag.

## Interface
- DIVISOR, default 5: modulus N; legal range 2..255.
- CNT_W, default 8: width of the bit counter; the counter saturates at 2^CNT_W-1.
- RW (localparam) = $clog2(DIVISOR): remainder width; minimum 1.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state on the same posedge.
- din_valid  in  1  qualifies din; no state changes when 0.
- din  in  1  serial data bit.
- start  in  1  marks the current qualified bit as the first bit of a new number; ignored when din_valid=0.
- lsb_first  in  1  bit order for the new number; sampled only on a first bit; 0 = MSB-first, 1 = LSB-first.
- dout  out  1  registered; 1 when a number is in progress and rem==0.
- rem  out  RW  registered running remainder, value mod DIVISOR.
- nbits  out  CNT_W  registered count of bits in the current number; saturating.
- active  out  1  registered; 1 once the first bit of a number has been accepted.

## Operation
- State registers: rem, pow (RW bits, LSB mode only), mode (1 bit, latched order), nbits, active.
- Reset values: rem=0, pow=1, mode=0, nbits=0, active=0, dout=0. dout stays 0 after reset until the first qualified bit, including for an empty number.
- First bit: a qualified cycle (din_valid=1) where start=1 or active=0.
  - mode ← lsb_first.
  - rem ← din.
  - pow ← 2 mod DIVISOR.
  - nbits ← 1.
  - active ← 1.
- Subsequent bits: a qualified cycle with start=0 and active=1.
  - MSB-first: rem ← (2·rem + din) mod DIVISOR. The intermediate value is RW+1 bits wide and is always < 2·DIVISOR, so it is reduced with one conditional subtract. No divider.
  - LSB-first: rem ← (rem + (din ? pow : 0)) mod DIVISOR, and pow ← (2·pow) mod DIVISOR. Both are reduced with one conditional subtract.
  - nbits ← nbits+1, saturating at 2^CNT_W-1. The remainder keeps updating after the counter saturates.
- din_valid=0: all registers hold. start and lsb_first are don't-care.
- start=1 mid-number: the current number is discarded and the current bit begins the new one. This does not need a gap cycle.
- lsb_first changes while a number is in progress have no effect.
- dout = active && (rem==0). It is derived from the registered state, so it is glitch-free.
- DIVISOR=2: pow becomes 0 after the first bit, so in LSB mode only bit 0 affects the remainder. This is the correct result.

## Timing
- Latency: one cycle. The bit accepted on edge k is reflected in rem, dout, nbits and active after edge k.
- Throughput: one bit per cycle, with no back-pressure.
- Reset has priority over din_valid and start in the same cycle.
- A reset mid-number aborts the number. The next qualified bit is a first bit whether or not start is asserted.
- The critical path is one adder, one compare and one subtract, all RW+1 bits wide.

## Test plan
- MSB-first, DIVISOR=5: bits 1,0,1,0 (value 10), start on the first bit. Required: rem=1,2,0,0; dout=0,0,1,1; nbits=1..4.
- LSB-first, DIVISOR=5: bits 0,1,0,1 (value 10), lsb_first=1 on the first bit. Required: pow sequence 1,2,4,3; rem=0,2,2,0; dout=1,0,0,1.
- Gaps: the MSB stream 1,1,0 (value 6) with din_valid=0 for 3 cycles between each bit. Required: outputs hold during gaps; final rem=1, dout=0, nbits=3.
- Restart and reset: DIVISOR=5, MSB bits 1,1 (rem=3), then start=1 with din=0. Required: rem=0, dout=1, nbits=1. Then reset=1 with din_valid=1 in the same cycle. Required: rem=0, dout=0, active=0 on the next cycle.
- DIVISOR=3, MSB-first, random 64-bit streams against a reference model. Required: rem matches value mod 3 after every bit, nbits saturates at 255 only with CNT_W=8 and length above 255, and rem stays correct after saturation.
- DIVISOR=7, LSB-first: bits 1,1,1 (value 7). Required: rem=1,3,0; dout=0,0,1. Also toggle lsb_first mid-number and check the result is unchanged.
